serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/full_adder_data.sv | 13 +
 rtl/serial_adder_ctrl.sv | 113 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract engine: state encoding
// and the default operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_data.sv
// One-bit dataflow full adder cell; purely combinational, no state.
module full_adder_data (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic Sum,
  output logic Carry
);

  assign Sum   = a ^ b ^ c;
  assign Carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell reused LSB first
// over WIDTH cycles, with carry-out and signed overflow registered at the end.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sb, acc;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             accept, last;
  logic             fa_s, fa_c;

  full_adder_data u_fa (
    .a     (sa[0]),
    .b     (sb[0]),
    .c     (carry_q),
    .Sum   (fa_s),
    .Carry (fa_c)
  );

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          last    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sa      <= '0;
      sb      <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == SHIFT);
      done  <= (state_n == DONE);
      if (accept) begin
        // Subtraction is a + ~b + 1: invert B and force the initial carry.
        sa      <= a;
        sb      <= sub ? ~b : b;
        carry_q <= sub ? 1'b1 : cin;
        cnt     <= '0;
        acc     <= '0;
        sum     <= '0;
        cout    <= 1'b0;
        ovf     <= 1'b0;
      end else if (state == SHIFT) begin
        acc     <= {fa_s, acc[WIDTH-1:1]};
        sa      <= sa >> 1;
        sb      <= sb >> 1;
        carry_q <= fa_c;
        if (last) begin
          // carry_q still holds the carry into the MSB during the final bit.
          sum  <= {fa_s, acc[WIDTH-1:1]};
          cout <= fa_c;
          ovf  <= carry_q ^ fa_c;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with a scoreboard of expected results.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk, rst, start, sub, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int   compares = 0;
  int   errs     = 0;
  exp_t sb[$];
  exp_t last_exp;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci);
    exp_t     m;
    logic [W:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    m.s = r[W-1:0];
    m.c = r[W];
    if (s) m.v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else   m.v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return m;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      compares++;
      errs++;
      $error("FAIL %s: observed result with empty scoreboard expected none", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_done"}, done, 1);
      chk({tag, "_sum"},  sum,  e.s);
      chk({tag, "_cout"}, cout, e.c);
      chk({tag, "_ovf"},  ovf,  e.v);
      last_exp = e;
    end
  endtask

  task automatic drive_start(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic ci, input logic expect_result);
    sub = s; a = x; b = y; cin = ci; start = 1'b1;
    if (expect_result) sb.push_back(model(s, x, y, ci));
  endtask

  // Counts cycles since the accepting edge until done, bounded.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 4 * W) begin
      if (busy === 1'b1 && done === 1'b1) chk("busy_and_done", 1, 0);
      tick;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic ci);
    int n;
    drive_start(s, x, y, ci, 1'b1);
    tick;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    n = 0;
    while (busy === 1'b1 && n < W + 4) begin
      chk({tag, "_nodone_busy"}, done, 0);
      chk({tag, "_sum_clr"}, sum, 0);
      n++;
      tick;
    end
    chk({tag, "_busy_len"}, n, W);
    chk({tag, "_busy_off"}, busy, 0);
    pop_compare(tag);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick; tick;
    // start coinciding with reset must be ignored
    drive_start(1'b0, 8'h11, 8'h22, 1'b0, 1'b0);
    tick;
    rst = 1'b0; start = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum",  sum,  0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf",  ovf,  0);
    tick;
    chk("rst_idle_busy", busy, 0);

    run_op("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 1'b0);
    tick;
    chk("done_pulse_one", done, 0);
    run_op("add_ff_00_c1", 1'b0, 8'hFF, 8'h00, 1'b1);
    run_op("sub_10_20", 1'b1, 8'h10, 8'h20, 1'b1);
    run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0);

    // start during SHIFT is ignored
    drive_start(1'b0, 8'h12, 8'h34, 1'b0, 1'b1);
    tick;
    start = 1'b0;
    tick; tick;
    drive_start(1'b1, 8'h77, 8'h66, 1'b1, 1'b0);
    tick;
    start = 1'b0;
    wait_done(4, n);
    chk("ign_latency", n, W + 1);
    pop_compare("ign_start");

    // back-to-back: start held in the DONE cycle
    drive_start(1'b0, 8'h01, 8'h01, 1'b0, 1'b1);
    tick;
    start = 1'b0;
    chk("b2b_busy_now", busy, 1);
    chk("b2b_done_off", done, 0);
    wait_done(1, n);
    chk("b2b_latency", n, W + 1);
    pop_compare("b2b");

    for (int i = 0; i < 20; i++) begin
      tick;
      chk("hold_done", done, 0);
      chk("hold_sum",  sum,  last_exp.s);
      chk("hold_cout", cout, last_exp.c);
      chk("hold_ovf",  ovf,  last_exp.v);
    end

    // reset mid-SHIFT discards the operation
    drive_start(1'b0, 8'hC3, 8'h5D, 1'b1, 1'b0);
    tick;
    start = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sum",  sum,  0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_ovf",  ovf,  0);
    n = 0;
    for (int i = 0; i < 2 * W; i++) begin
      tick;
      if (done === 1'b1 || busy === 1'b1) n++;
    end
    chk("mid_rst_quiet", n, 0);

    run_op("post_rst_7f_01", 1'b0, 8'h7F, 8'h01, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_op("rand", 1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
    end

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errs);
    $finish;
  end

endmodule
